hog_cell_histogram: RTL and testbench

Accumulates per-pixel orientation votes into 9-bin HOG cell histograms. Sits directly downstream of the orientation binning stage. It consumes a raster-order stream of (bin index 0..8, gradient magnitude) pairs and emits one completed histogram per CELL_SIZE×CELL_SIZE cell on a valid/ready output toward block normalisation. Partial histograms for one full row of cells are held internally, so the input never needs to be re-scanned.

---
 rtl/hog_cell_histogram.sv | 129 ++++++++++++
 tb/tb_hog_cell_histogram.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hog_cell_histogram.sv
// hog_cell_histogram: folds (bin, magnitude) pixel votes into 9-bin
// histograms, one per CELL_SIZE x CELL_SIZE cell, keeping one row of cells.
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid/in_ready  pixel handshake; bin_in (0..8 valid), mag_in
//   out_valid/out_ready completed-cell handshake; hist_out (bin k at
//                      [k*HIST_WIDTH +: HIST_WIDTH]), cell_col, cell_row
//   frame_done         pulse after the frame's last cell is accepted
module hog_cell_histogram #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CELL_SIZE  = 8,
  parameter int MAG_WIDTH  = 9,
  parameter int HIST_WIDTH = 15,
  localparam int NCOL = IMG_WIDTH / CELL_SIZE,
  localparam int NROW = IMG_HEIGHT / CELL_SIZE,
  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1,
  localparam int RW = (NROW > 1) ? $clog2(NROW) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              bin_in,
  input  logic [MAG_WIDTH-1:0]    mag_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [9*HIST_WIDTH-1:0] hist_out,
  output logic [CW-1:0]           cell_col,
  output logic [RW-1:0]           cell_row,
  output logic                    frame_done
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LC = $clog2(CELL_SIZE);
  localparam int SW =
    ((HIST_WIDTH > MAG_WIDTH) ? HIST_WIDTH : MAG_WIDTH) + 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [HIST_WIDTH-1:0] acc [NCOL][9];
  logic [HIST_WIDTH-1:0] upd [9];
  logic [9*HIST_WIDTH-1:0] upd_flat;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic hs, x_last, y_last, cell_done;

  function automatic logic [HIST_WIDTH-1:0] sat_add(
    input logic [HIST_WIDTH-1:0] a,
    input logic [MAG_WIDTH-1:0]  m
  );
    logic [SW-1:0] s;
    s = SW'(a) + SW'(m);
    if (s > SW'({HIST_WIDTH{1'b1}}))
      return {HIST_WIDTH{1'b1}};
    return s[HIST_WIDTH-1:0];
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign hs = in_valid && in_ready;
  assign col = CW'(x >> LC);
  assign row = RW'(y >> LC);
  assign x_last = (x == XW'(IMG_WIDTH - 1));
  assign y_last = (y == YW'(IMG_HEIGHT - 1));
  assign cell_done =
    ((x & XW'(CELL_SIZE - 1)) == XW'(CELL_SIZE - 1)) &&
    ((y & YW'(CELL_SIZE - 1)) == YW'(CELL_SIZE - 1));

  // Column entry with this pixel's vote folded in; bins >= 9 never match.
  always_comb begin
    upd_flat = '0;
    for (int k = 0; k < 9; k++) begin
      upd[k] = acc[col][k];
      if (bin_in == 4'(k))
        upd[k] = sat_add(acc[col][k], mag_in);
      upd_flat[k*HIST_WIDTH +: HIST_WIDTH] = upd[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (hs) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Completing pixel empties the entry so the next cell row starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCOL; c++)
        for (int k = 0; k < 9; k++)
          acc[c][k] <= '0;
    end else if (hs) begin
      for (int k = 0; k < 9; k++)
        acc[col][k] <= cell_done ? '0 : upd[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      hist_out   <= '0;
      cell_col   <= '0;
      cell_row   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready &&
                    cell_col == CW'(NCOL - 1) &&
                    cell_row == RW'(NROW - 1);
      if (hs && cell_done) begin
        out_valid <= 1'b1;
        hist_out  <= upd_flat;
        cell_col  <= col;
        cell_row  <= row;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hog_cell_histogram.sv
// tb_hog_cell_histogram: random and directed frames on a 16x8 image,
// two instances (15-bit and 14-bit bins) against a cell-level model.
module tb_hog_cell_histogram;

  localparam int W = 16;
  localparam int H = 8;
  localparam int CS = 8;
  localparam int HA = 15;
  localparam int HB = 14;
  localparam int NCOL = W / CS;
  localparam int NROW = H / CS;
  localparam int CAPA = (1 << HA) - 1;
  localparam int CAPB = (1 << HB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] bin_in = '0;
  logic [8:0] mag_in = '0;
  logic in_ready_a, in_ready_b;
  logic out_valid_a, out_valid_b;
  logic fd_a, fd_b;
  logic [9*HA-1:0] hist_a;
  logic [9*HB-1:0] hist_b;
  logic [0:0] col_a, col_b, row_a, row_b;

  always #5 clk = ~clk;

  hog_cell_histogram #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CELL_SIZE(CS),
    .MAG_WIDTH(9), .HIST_WIDTH(HA)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .bin_in(bin_in), .mag_in(mag_in),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .hist_out(hist_a), .cell_col(col_a), .cell_row(row_a),
    .frame_done(fd_a)
  );

  hog_cell_histogram #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CELL_SIZE(CS),
    .MAG_WIDTH(9), .HIST_WIDTH(HB)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .bin_in(bin_in), .mag_in(mag_in),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .hist_out(hist_b), .cell_col(col_b), .cell_row(row_b),
    .frame_done(fd_b)
  );

  int raw [NCOL][9];
  int mx, my, age, frames;
  bit fd_exp;
  logic [9*HA-1:0] qa[$];
  logic [9*HB-1:0] qb[$];
  int qc[$];
  int qr[$];
  bit dir_on;
  logic [9*HA-1:0] dir_a;
  logic [9*HB-1:0] dir_b;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [9*HA-1:0] pack_a(input int c);
    logic [9*HA-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      v = (raw[c][k] > CAPA) ? CAPA : raw[c][k];
      r[k*HA +: HA] = v[HA-1:0];
    end
    return r;
  endfunction

  function automatic logic [9*HB-1:0] pack_b(input int c);
    logic [9*HB-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      v = (raw[c][k] > CAPB) ? CAPB : raw[c][k];
      r[k*HB +: HB] = v[HB-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCOL; c++)
      for (int k = 0; k < 9; k++)
        raw[c][k] = 0;
    mx = 0; my = 0; age = 0; fd_exp = 0;
    qa.delete(); qb.delete(); qc.delete(); qr.delete();
  endtask

  // 0 random, 1 uniform, 2 backpressure, 3 invalid bins,
  // 4 saturation, 5 clean, 6 stalled output, 7 junk pre-reset.
  task automatic drive(input int mode);
    in_valid = 1'b1;
    out_ready = 1'b1;
    bin_in = 4'($urandom_range(0, 11));
    mag_in = 9'($urandom_range(0, 511));
    case (mode)
      0: begin
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end
      1: begin bin_in = 4'd3; mag_in = 9'd10; end
      2: out_ready = !(qa.size() != 0 && age < 5);
      3: begin
        bin_in = (my % CS < 4) ? 4'd12 : 4'd0;
        mag_in = (my % CS < 4) ? 9'd100 : 9'd1;
      end
      4: begin bin_in = 4'd8; mag_in = 9'd511; end
      5: begin bin_in = 4'd2; mag_in = 9'd1; end
      6: out_ready = 1'b0;
      7: begin bin_in = 4'd5; mag_in = 9'd7; end
      default: in_valid = 1'b0;
    endcase
  endtask

  task automatic check_outputs();
    bit exp_rdy;
    exp_rdy = (qa.size() == 0) || out_ready;
    chk("in_ready_a", in_ready_a, exp_rdy);
    chk("in_ready_b", in_ready_b, exp_rdy);
    chk("out_valid_a", out_valid_a, qa.size() != 0);
    chk("out_valid_b", out_valid_b, qa.size() != 0);
    if (qa.size() != 0) begin
      chk("hist_a", hist_a, qa[0]);
      chk("hist_b", hist_b, qb[0]);
      chk("cell_col", col_a, qc[0]);
      chk("cell_row", row_a, qr[0]);
      if (dir_on) begin
        chk("dir_hist_a", hist_a, dir_a);
        chk("dir_hist_b", hist_b, dir_b);
      end
    end
    chk("frame_done_a", fd_a, fd_exp);
    chk("frame_done_b", fd_b, fd_exp);
    if (fd_exp) frames++;
  endtask

  task automatic step();
    bit hs, ohs, fd_next;
    int c, r, b, m, cx;
    hs = in_valid && ((qa.size() == 0) || out_ready);
    ohs = (qa.size() != 0) && out_ready;
    b = int'(bin_in);
    m = int'(mag_in);
    @(posedge clk);
    fd_next = 0;
    if (ohs) begin
      c = qc.pop_front();
      r = qr.pop_front();
      void'(qa.pop_front());
      void'(qb.pop_front());
      fd_next = (c == NCOL - 1) && (r == NROW - 1);
    end
    if (hs) begin
      cx = mx / CS;
      if (b < 9) raw[cx][b] += m;
      if (mx % CS == CS - 1 && my % CS == CS - 1) begin
        qa.push_back(pack_a(cx));
        qb.push_back(pack_b(cx));
        qc.push_back(cx);
        qr.push_back(my / CS);
        for (int k = 0; k < 9; k++) raw[cx][k] = 0;
      end
      mx++;
      if (mx == W) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end
    end
    age = (ohs || qa.size() == 0) ? 0 : age + 1;
    fd_exp = fd_next;
  endtask

  task automatic run(input int mode, input int max_cyc,
                     input bit to_frame);
    int f0;
    int c;
    f0 = frames;
    c = 0;
    while (c < max_cyc && !(to_frame && frames != f0)) begin
      @(negedge clk);
      drive(mode);
      #1;
      check_outputs();
      step();
      c++;
    end
    if (to_frame) chk("frame_reached", frames != f0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {out_valid_a, out_valid_b}, 2'b00);
    chk("rst_hist_a", hist_a, '0);
    chk("rst_hist_b", hist_b, '0);
    chk("rst_frame_done", {fd_a, fd_b}, 2'b00);
    chk("rst_in_ready", {in_ready_a, in_ready_b}, 2'b11);
    chk("rst_cell_pos", {col_a, row_a}, 2'b00);
  endtask

  function automatic logic [9*HA-1:0] one_a(input int k, input int v);
    logic [9*HA-1:0] r;
    r = '0;
    r[k*HA +: HA] = HA'(v);
    return r;
  endfunction

  function automatic logic [9*HB-1:0] one_b(input int k, input int v);
    logic [9*HB-1:0] r;
    r = '0;
    r[k*HB +: HB] = HB'(v);
    return r;
  endfunction

  initial begin
    frames = 0;
    dir_on = 0;
    dir_a = '0;
    dir_b = '0;
    model_reset();
    do_reset();

    run(6, 150, 0);
    do_reset();

    dir_on = 1;
    dir_a = one_a(3, 640);
    dir_b = one_b(3, 640);
    run(1, 400, 1);
    dir_on = 0;

    do_reset();
    run(2, 600, 1);
    run(2, 600, 1);

    do_reset();
    dir_on = 1;
    dir_a = one_a(0, 32);
    dir_b = one_b(0, 32);
    run(3, 400, 1);
    dir_on = 0;

    do_reset();
    dir_on = 1;
    dir_a = one_a(8, 32704);
    dir_b = one_b(8, 16383);
    run(4, 400, 1);
    dir_on = 0;

    do_reset();
    run(7, 3 * W, 0);
    do_reset();
    dir_on = 1;
    dir_a = one_a(2, 64);
    dir_b = one_b(2, 64);
    run(5, 400, 1);
    dir_on = 0;

    for (int f = 0; f < 4; f++) run(0, 3000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
